// File: rtl/trace_pkg.sv
// trace_pkg: shared state encodings, trigger modes and trace entry layout.
package trace_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_POST, ST_DONE} state_t;
  localparam logic TRIG_PC  = 1'b0;
  localparam logic TRIG_REG = 1'b1;
  // Entry packing, LSB first: wb_data, wb_reg, wb_we, insn, pc
  function automatic int off_reg(input int dw);
    return dw;
  endfunction
  function automatic int off_we(input int dw);
    return dw + 5;
  endfunction
  function automatic int off_insn(input int dw);
    return dw + 6;
  endfunction
  function automatic int off_pc(input int dw);
    return 2 * dw + 6;
  endfunction
  function automatic int entry_w(input int aw, input int dw);
    return aw + dw + 1 + 5 + dw;
  endfunction
endpackage

// File: rtl/trace_ram.sv
// trace_ram: simple dual-port memory, synchronous write and 1-cycle registered read.
module trace_ram #(
  parameter int W     = 82,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/trace_capture.sv
// trace_capture: circular retired-instruction trace with trigger, post-trigger window and oldest-first replay.
module trace_capture
  import trace_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 64,
  parameter int POST_TRIG = 16,
  parameter int IDX_W     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_en,
  input  logic [ADDR_W-1:0] pc,
  input  logic [DATA_W-1:0] insn,
  input  logic              wb_we,
  input  logic [4:0]        wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              arm,
  input  logic              trig_mode,
  input  logic [ADDR_W-1:0] trig_pc,
  input  logic [4:0]        trig_reg,
  input  logic              force_trig,
  output logic [1:0]        state,
  output logic [IDX_W:0]    count,
  output logic              done,
  output logic [IDX_W-1:0]  trig_idx,
  input  logic              rd_req,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] rd_pc,
  output logic [DATA_W-1:0] rd_insn,
  output logic              rd_wb_we,
  output logic [4:0]        rd_wb_reg,
  output logic [DATA_W-1:0] rd_wb_data
);
  localparam int EW = entry_w(ADDR_W, DATA_W);
  localparam logic [IDX_W:0] FULL = (IDX_W+1)'(DEPTH);
  state_t state_q, state_d;
  logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d, post_cnt_q, post_cnt_d, trig_idx_q, trig_idx_d, raddr;
  logic [IDX_W:0] count_q, count_d;
  logic rd_valid_q, rd_zero_q, hit, wr_en, rd_fire;
  logic [EW-1:0] wdata, rdata, rd_entry;
  assign hit = sample_en && (force_trig || (trig_mode == TRIG_PC && pc == trig_pc) ||
               (trig_mode == TRIG_REG && wb_we && wb_reg == trig_reg));
  assign wr_en = sample_en && !arm && (state_q == ST_ARMED || state_q == ST_POST);
  assign rd_fire = rd_req && state_q == ST_DONE;
  // Once the buffer has wrapped, the oldest entry sits at the write pointer
  assign raddr = (count_q == FULL ? wr_ptr_q : '0) + rd_idx;
  assign wdata = {pc, insn, wb_we, wb_reg, wb_data};
  trace_ram #(.W(EW), .DEPTH(DEPTH), .AW(IDX_W)) u_ram (
    .clk(clk), .we(wr_en), .waddr(wr_ptr_q), .wdata(wdata), .raddr(raddr), .rdata(rdata)
  );
  always_comb begin
    state_d = state_q;
    wr_ptr_d = wr_ptr_q;
    count_d = count_q;
    post_cnt_d = post_cnt_q;
    trig_idx_d = trig_idx_q;
    if (arm) begin
      state_d = ST_ARMED;
      wr_ptr_d = '0;
      count_d = '0;
    end else if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      count_d = count_q == FULL ? count_q : count_q + 1'b1;
      if (state_q == ST_ARMED && hit) begin
        post_cnt_d = IDX_W'(POST_TRIG);
        state_d = POST_TRIG == 0 ? ST_DONE : ST_POST;
      end else if (state_q == ST_POST) begin
        post_cnt_d = post_cnt_q - 1'b1;
        state_d = post_cnt_q == IDX_W'(1) ? ST_DONE : ST_POST;
      end
    end
    if (state_d == ST_DONE && state_q != ST_DONE)
      trig_idx_d = IDX_W'(count_d - 1'b1 - (IDX_W+1)'(POST_TRIG));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wr_ptr_q <= '0;
      count_q <= '0;
      post_cnt_q <= '0;
      trig_idx_q <= '0;
      rd_valid_q <= 1'b0;
      rd_zero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      count_q <= count_d;
      post_cnt_q <= post_cnt_d;
      trig_idx_q <= trig_idx_d;
      rd_valid_q <= rd_fire;
      rd_zero_q <= {1'b0, rd_idx} >= count_q;
    end
  end
  assign rd_entry = rd_valid_q && !rd_zero_q ? rdata : '0;
  assign state = state_q;
  assign count = count_q;
  assign done = state_q == ST_DONE;
  assign trig_idx = trig_idx_q;
  assign rd_valid = rd_valid_q;
  assign rd_pc = rd_entry[off_pc(DATA_W) +: ADDR_W];
  assign rd_insn = rd_entry[off_insn(DATA_W) +: DATA_W];
  assign rd_wb_we = rd_entry[off_we(DATA_W)];
  assign rd_wb_reg = rd_entry[off_reg(DATA_W) +: 5];
  assign rd_wb_data = rd_entry[0 +: DATA_W];
endmodule

// File: tb/tb_trace_capture.sv
// tb_trace_capture: directed vectors and corner-case sequences for trace_capture (DEPTH=8, POST_TRIG=2).
module tb_trace_capture;
  localparam int AW = 12, DW = 32, D = 8, PT = 2, IW = 3;
  logic clk = 0, rst = 1, sample_en = 0, wb_we = 0, arm = 0, trig_mode = 0, force_trig = 0, rd_req = 0;
  logic [AW-1:0] pc = '0, trig_pc = '0;
  logic [DW-1:0] insn = '0, wb_data = '0;
  logic [4:0] wb_reg = '0, trig_reg = '0;
  logic [IW-1:0] rd_idx = '0, trig_idx;
  logic [1:0] state;
  logic [IW:0] count;
  logic done, rd_valid, rd_wb_we;
  logic [AW-1:0] rd_pc;
  logic [DW-1:0] rd_insn, rd_wb_data;
  logic [4:0] rd_wb_reg;
  int errors = 0, checks = 0;
  typedef struct {
    logic arm;
    logic se;
    logic [AW-1:0] pc;
    logic [1:0] st;
    logic [IW:0] cnt;
  } vec_t;
  vec_t v[7];
  trace_capture #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(D), .POST_TRIG(PT)) dut (
    .clk(clk), .rst(rst), .sample_en(sample_en), .pc(pc), .insn(insn), .wb_we(wb_we),
    .wb_reg(wb_reg), .wb_data(wb_data), .arm(arm), .trig_mode(trig_mode), .trig_pc(trig_pc),
    .trig_reg(trig_reg), .force_trig(force_trig), .state(state), .count(count), .done(done),
    .trig_idx(trig_idx), .rd_req(rd_req), .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_pc(rd_pc),
    .rd_insn(rd_insn), .rd_wb_we(rd_wb_we), .rd_wb_reg(rd_wb_reg), .rd_wb_data(rd_wb_data)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic samp(input logic se, input int p);
    sample_en = se;
    pc = AW'(p);
    insn = {20'hC0000, AW'(p)};
  endtask
  task automatic rd(input int idx);
    rd_req = 1;
    rd_idx = IW'(idx);
    step;
    rd_req = 0;
  endtask
  task automatic run_samples(input int lo, input int hi);
    for (int p = lo; p <= hi; p++) begin
      samp(1, p);
      step;
    end
    samp(0, 0);
  endtask
  initial begin
    v[0] = '{1'b1, 1'b0, 12'd0, 2'd1, 4'd0};
    v[1] = '{1'b0, 1'b1, 12'd0, 2'd1, 4'd1};
    v[2] = '{1'b0, 1'b1, 12'd1, 2'd1, 4'd2};
    v[3] = '{1'b0, 1'b1, 12'd2, 2'd2, 4'd3};
    v[4] = '{1'b0, 1'b1, 12'd3, 2'd2, 4'd4};
    v[5] = '{1'b0, 1'b1, 12'd4, 2'd3, 4'd5};
    v[6] = '{1'b0, 1'b1, 12'd5, 2'd3, 4'd5};
    step;
    step;
    rst = 0;
    chk("rst_state", 32'(state), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_trig_idx", 32'(trig_idx), 0);
    // Basic pc trigger, table driven
    trig_mode = 0;
    trig_pc = 2;
    for (int i = 0; i < 7; i++) begin
      arm = v[i].arm;
      samp(v[i].se, int'(v[i].pc));
      step;
      chk($sformatf("vec%0d_state", i), 32'(state), 32'(v[i].st));
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(v[i].cnt));
    end
    arm = 0;
    samp(0, 0);
    chk("s2_done", 32'(done), 1);
    chk("s2_trig_idx", 32'(trig_idx), 2);
    rd(0);
    chk("s2_rd0_valid", 32'(rd_valid), 1);
    chk("s2_rd0_pc", 32'(rd_pc), 0);
    chk("s2_rd0_insn", rd_insn, 32'hC0000000);
    rd(4);
    chk("s2_rd4_pc", 32'(rd_pc), 4);
    chk("s2_rd4_insn", rd_insn, 32'hC0000004);
    step;
    chk("s2_pulse", 32'(rd_valid), 0);
    // Reset mid-stream with a pending read
    rd_req = 1;
    rd_idx = 1;
    rst = 1;
    step;
    rd_req = 0;
    chk("s1_lost_read", 32'(rd_valid), 0);
    step;
    rst = 0;
    chk("s1_state", 32'(state), 0);
    chk("s1_count", 32'(count), 0);
    chk("s1_done", 32'(done), 0);
    chk("s1_trig_idx", 32'(trig_idx), 0);
    chk("s1_rd_pc", 32'(rd_pc), 0);
    chk("s1_rd_insn", rd_insn, 0);
    chk("s1_rd_wb", {rd_wb_data[15:0], 10'd0, rd_wb_we, rd_wb_reg}, 0);
    // Wrap-around
    trig_pc = 15;
    arm = 1;
    step;
    arm = 0;
    run_samples(0, 19);
    chk("s3_state", 32'(state), 3);
    chk("s3_count", 32'(count), 8);
    chk("s3_trig_idx", 32'(trig_idx), 5);
    rd_req = 1;
    rd_idx = 0;
    step;
    chk("s3_rd0_pc", 32'(rd_pc), 10);
    rd_idx = 7;
    step;
    chk("s3_rd7_pc", 32'(rd_pc), 17);
    chk("s3_rd7_valid", 32'(rd_valid), 1);
    rd_idx = 5;
    step;
    rd_req = 0;
    chk("s3_rd5_pc", 32'(rd_pc), 15);
    step;
    chk("s3_pulse", 32'(rd_valid), 0);
    // Register-write trigger
    trig_mode = 1;
    trig_reg = 5;
    arm = 1;
    step;
    arm = 0;
    samp(1, 12'h100);
    wb_we = 0;
    wb_reg = 5;
    wb_data = 32'h11111111;
    step;
    chk("s4_we0_state", 32'(state), 1);
    samp(1, 12'h101);
    wb_we = 1;
    wb_reg = 3;
    step;
    chk("s4_reg3_state", 32'(state), 1);
    samp(1, 12'h102);
    wb_reg = 5;
    wb_data = 32'hDEADBEEF;
    step;
    chk("s4_hit_state", 32'(state), 2);
    wb_we = 0;
    wb_data = 0;
    run_samples(12'h103, 12'h104);
    chk("s4_state", 32'(state), 3);
    chk("s4_trig_idx", 32'(trig_idx), 2);
    rd(2);
    chk("s4_wb_data", rd_wb_data, 32'hDEADBEEF);
    chk("s4_wb_we", 32'(rd_wb_we), 1);
    chk("s4_wb_reg", 32'(rd_wb_reg), 5);
    chk("s4_pc", 32'(rd_pc), 32'h102);
    // Gaps in the post-trigger window
    trig_mode = 0;
    trig_pc = 3;
    arm = 1;
    step;
    arm = 0;
    run_samples(0, 3);
    chk("s5_trig_state", 32'(state), 2);
    samp(1, 4);
    step;
    chk("s5_post1_state", 32'(state), 2);
    samp(0, 0);
    rd_req = 1;
    rd_idx = 0;
    step;
    rd_req = 0;
    chk("s5_gap1_state", 32'(state), 2);
    chk("s5_post_read", 32'(rd_valid), 0);
    step;
    chk("s5_gap2_count", 32'(count), 5);
    samp(1, 5);
    step;
    samp(0, 0);
    chk("s5_state", 32'(state), 3);
    chk("s5_count", 32'(count), 6);
    rd(7);
    chk("s5_oob_valid", 32'(rd_valid), 1);
    chk("s5_oob_pc", 32'(rd_pc), 0);
    chk("s5_oob_insn", rd_insn, 0);
    // arm priority over trigger, then arm with read in DONE
    trig_pc = 2;
    arm = 1;
    step;
    arm = 0;
    run_samples(0, 1);
    arm = 1;
    samp(1, 2);
    step;
    arm = 0;
    samp(0, 0);
    chk("s6_arm_hit_state", 32'(state), 1);
    chk("s6_arm_hit_count", 32'(count), 0);
    run_samples(10, 11);
    run_samples(2, 2);
    run_samples(12, 13);
    chk("s6_done_state", 32'(state), 3);
    chk("s6_done_count", 32'(count), 5);
    arm = 1;
    rd_req = 1;
    rd_idx = 0;
    step;
    arm = 0;
    rd_req = 0;
    chk("s6_rearm_state", 32'(state), 1);
    chk("s6_rearm_valid", 32'(rd_valid), 1);
    chk("s6_rearm_pc", 32'(rd_pc), 10);
    chk("s6_rearm_count", 32'(count), 0);
    step;
    chk("s6_after_valid", 32'(rd_valid), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/trace_capture.md
Name: trace_capture

Overview:
Parametrised on-chip instruction trace buffer for the skeleton processor. It records one entry per retired instruction: pc, insn and register write-back. Recording is circular and continues until a trigger, then for a fixed number of post-trigger samples, after which the buffer freezes. A read port then replays the frozen entries oldest-first. This is the synthesizable replacement for the per-cycle trace that the test bench prints with its display loop.

Parameters:
ADDR_W, 12, pc / imem address width
DATA_W, 32, insn and write-back data width
DEPTH, 64, entry count; power of 2, at least 2
POST_TRIG, 16, samples recorded after the trigger entry; 0 to DEPTH-1
IDX_W, log2(DEPTH), read index width (derived)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
sample_en  in  1  current pc/insn/wb_* form a valid retired sample
pc  in  ADDR_W  sampled pc
insn  in  DATA_W  sampled instruction
wb_we  in  1  regfile write enable of the sample
wb_reg  in  5  regfile write address
wb_data  in  DATA_W  regfile write data
arm  in  1  pulse; clear the buffer and start recording
trig_mode  in  1  0 = pc match, 1 = register-write match
trig_pc  in  ADDR_W  pc compare value
trig_reg  in  5  register compare value
force_trig  in  1  treat the current sample as the trigger
state  out  2  IDLE=0, ARMED=1, POST=2, DONE=3
count  out  IDX_W+1  valid entries, saturates at DEPTH
done  out  1  state==DONE
trig_idx  out  IDX_W  read-order index of the trigger entry, valid in DONE
rd_req  in  1  read request, honoured only in DONE
rd_idx  in  IDX_W  read-order index, 0 = oldest
rd_valid  out  1  read data valid
rd_pc, rd_insn, rd_wb_we, rd_wb_reg, rd_wb_data  out  match inputs  read entry fields

Behaviour:
- Reset: state IDLE; count, wr_ptr, post_cnt, trig_idx, rd_valid and all rd_* outputs are 0. Memory contents are not cleared.
- A sample is a cycle with sample_en=1.
- Trigger hit: sample_en and (force_trig, or trig_mode=0 and pc==trig_pc, or trig_mode=1 and wb_we and wb_reg==trig_reg).
- IDLE: no recording. arm sets wr_ptr=0 and count=0, then goes to ARMED. The sample in the arm cycle is dropped.
- ARMED: each sample is written at wr_ptr; wr_ptr=(wr_ptr+1) mod DEPTH; count=min(count+1, DEPTH).
  - On a trigger hit the triggering sample is written.
  - With POST_TRIG>0: post_cnt=POST_TRIG, go to POST.
  - With POST_TRIG=0: go directly to DONE.
- POST: each sample is written and post_cnt is decremented. After the write that brings post_cnt to 0, go to DONE. Trigger hits are ignored. Cycles without a sample do not change post_cnt.
- DONE: no writes and done=1. arm restarts exactly as from IDLE.
- arm in ARMED or POST: restart (clear, go to ARMED). The concurrent sample is dropped and arm has priority over a trigger hit.
- Oldest physical slot: 0 if count<DEPTH, else wr_ptr.
- Read addressing: physical=(oldest+rd_idx) mod DEPTH.
- trig_idx=count-1-POST_TRIG, registered on entry to DONE.
- Read, DONE only: rd_req gives rd_valid=1 and the entry fields exactly 1 cycle later.
  - rd_idx>=count: rd_valid=1 with all fields 0.
  - rd_req outside DONE: ignored, rd_valid=0.
  - rd_valid is a 1-cycle pulse per request; back-to-back requests give one result per cycle.
- rd_req and arm in the same DONE cycle: the read is served from the frozen data and the state becomes ARMED.
- rst mid-operation (any state): returns to IDLE per the reset values. A pending read is lost (rd_valid=0 next cycle).

Decomposition:
- Package trace_pkg:
  - state encodings ST_IDLE, ST_ARMED, ST_POST, ST_DONE
  - TRIG_PC and TRIG_REG mode constants
  - entry field offsets and total entry width: ADDR_W+DATA_W+1+5+DATA_W
- Sub-module trace_ram: simple dual-port, DEPTH x entry width, one synchronous write port and one synchronous read port with 1-cycle read latency. Sized for an altsyncram-style inference.
- FSM, pointers and index arithmetic stay in trace_capture.

Test Plan:
All scenarios use DEPTH=8, POST_TRIG=2.
1. Assert rst for 2 cycles mid-stream -> state=0, count=0, done=0, rd_valid=0, all rd_* outputs 0.
2. arm; samples pc=0..5; trig_mode=0, trig_pc=2 -> DONE after pc 4; count=5; trig_idx=2; rd_idx 0/4 -> rd_pc 0/4 one cycle later; pc 5 not recorded.
3. Wrap: arm; samples pc=0..19; trig_pc=15 -> DONE after pc 17; count=8; rd_idx 0 -> pc 10; rd_idx 7 -> pc 17; trig_idx=5.
4. Register mode, trig_reg=5:
   - sample with wb_reg=5, wb_we=0 -> no trigger
   - later sample with wb_we=1, wb_reg=5, wb_data=0xDEADBEEF -> trigger
   - read at trig_idx -> rd_wb_data=0xDEADBEEF, rd_wb_we=1
5. Trigger, then sample_en toggling 1,0,0,1 -> DONE only after the 2nd post sample; rd_req while in POST -> rd_valid stays 0; rd_idx=7 with count=6 -> zero fields and rd_valid=1.
6. arm in the same cycle as a trigger hit in ARMED -> state ARMED, count=0; arm plus rd_req in DONE -> valid read returned, state=1.
